// File: rtl/earom_ctrl_if.sv
// Host-side request/acknowledge port used by the hiscore loader/saver to reach
// the EAROM array between CPU operations.
interface earom_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_a;
  logic [7:0]        host_d;
  logic [7:0]        host_q;
  logic              host_ack;

  modport master (
    output host_req, host_we, host_a, host_d,
    input  host_q, host_ack
  );

  modport slave (
    input  host_req, host_we, host_a, host_d,
    output host_q, host_ack
  );
endinterface

// File: rtl/earom_ctrl.sv
// CPU/host sequencer for the high-score EAROM: turns control-register writes and
// host requests into single-cycle array commands, models busy time, returns reads.
module earom_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int BUSY_CYCLES = 16,
  parameter int BUSY_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_addr_wr,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_d,
  input  logic              cpu_ctrl_wr,
  input  logic [3:0]        cpu_ctrl,
  output logic [7:0]        cpu_rd_data,
  output logic              busy,
  earom_ctrl_if.slave       host,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_din,
  output logic              ram_c1,
  output logic              ram_c2,
  output logic              ram_cs1,
  output logic              ram_rclk,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_BUSYW, S_RD, S_RDCAP} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_lat_a;
  logic [7:0]        r_lat_d;
  logic              r_eclk_prev;
  logic [ADDR_W-1:0] r_op_a, w_op_a_next;
  logic [7:0]        r_op_d, w_op_d_next;
  logic              r_op_erase, w_op_erase_next;
  logic              r_op_host, w_op_host_next;
  logic [BUSY_W-1:0] r_cnt, w_cnt_next;

  logic [ADDR_W-1:0] r_ram_a, w_ram_a_next;
  logic [7:0]        r_ram_din, w_ram_din_next;
  logic              r_ram_c1, w_ram_c1_next;
  logic              r_ram_c2, w_ram_c2_next;
  logic              r_ram_cs1, w_ram_cs1_next;
  logic              r_ram_rclk, w_ram_rclk_next;
  logic [7:0]        r_cpu_rd, w_cpu_rd_next;
  logic [7:0]        r_host_q, w_host_q_next;
  logic              r_host_ack, w_host_ack_next;

  logic [ADDR_W-1:0] w_eff_a;
  logic [7:0]        w_eff_d;
  logic [1:0]        w_cpu_op;
  logic              w_trig;
  logic              w_host_go;

  // A same-cycle address write is visible to the trigger it accompanies.
  assign w_eff_a  = cpu_addr_wr ? cpu_a : r_lat_a;
  assign w_eff_d  = cpu_addr_wr ? cpu_d : r_lat_d;
  assign w_cpu_op = cpu_ctrl[2:1];
  assign w_trig   = cpu_ctrl_wr & cpu_ctrl[0] & ~r_eclk_prev & cpu_ctrl[3] & (w_cpu_op != 2'b11);
  // Ignoring host_req during the ack cycle prevents a stale request from re-issuing.
  assign w_host_go = host.host_req & ~r_host_ack;

  always_comb begin
    w_state_next    = r_state;
    w_op_a_next     = r_op_a;
    w_op_d_next     = r_op_d;
    w_op_erase_next = r_op_erase;
    w_op_host_next  = r_op_host;
    w_cnt_next      = r_cnt;
    w_ram_a_next    = r_ram_a;
    w_ram_din_next  = r_ram_din;
    w_ram_c1_next   = 1'b1;
    w_ram_c2_next   = 1'b1;
    w_ram_cs1_next  = 1'b0;
    w_ram_rclk_next = 1'b0;
    w_cpu_rd_next   = r_cpu_rd;
    w_host_q_next   = r_host_q;
    w_host_ack_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_op_a_next     = w_eff_a;
          w_op_d_next     = w_eff_d;
          w_op_host_next  = 1'b0;
          w_op_erase_next = w_cpu_op[0];
          w_state_next    = w_cpu_op[1] ? S_RD : S_CMD;
        end else if (w_host_go) begin
          w_op_a_next     = host.host_a;
          w_op_d_next     = host.host_d;
          w_op_host_next  = 1'b1;
          w_op_erase_next = 1'b0;
          w_state_next    = host.host_we ? S_CMD : S_RD;
        end
      end
      S_CMD: begin
        w_state_next = S_BUSYW;
        w_cnt_next   = BUSY_W'(BUSY_CYCLES - 1);
      end
      S_BUSYW: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - BUSY_W'(1);
        end
      end
      S_RD: begin
        w_state_next = S_RDCAP;
      end
      S_RDCAP: begin
        w_state_next = S_IDLE;
        if (r_op_host) begin
          w_host_q_next   = ram_dout;
          w_host_ack_next = 1'b1;
        end else begin
          w_cpu_rd_next = ram_dout;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Array outputs are registered from the next state so they line up with it.
    if (w_state_next == S_CMD) begin
      w_ram_cs1_next = 1'b1;
      w_ram_c1_next  = 1'b0;
      w_ram_c2_next  = w_op_erase_next;
      w_ram_a_next   = w_op_a_next;
      w_ram_din_next = w_op_d_next;
    end else if (w_state_next == S_RD) begin
      w_ram_cs1_next  = 1'b1;
      w_ram_c1_next   = 1'b1;
      w_ram_c2_next   = 1'b0;
      w_ram_rclk_next = 1'b1;
      w_ram_a_next    = w_op_a_next;
    end

    if (w_op_host_next && (w_state_next == S_BUSYW) && (w_cnt_next == '0)) begin
      w_host_ack_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lat_a     <= '0;
      r_lat_d     <= '0;
      r_eclk_prev <= 1'b0;
      r_op_a      <= '0;
      r_op_d      <= '0;
      r_op_erase  <= 1'b0;
      r_op_host   <= 1'b0;
      r_cnt       <= '0;
      r_ram_a     <= '0;
      r_ram_din   <= '0;
      r_ram_c1    <= 1'b1;
      r_ram_c2    <= 1'b1;
      r_ram_cs1   <= 1'b0;
      r_ram_rclk  <= 1'b0;
      r_cpu_rd    <= '0;
      r_host_q    <= '0;
      r_host_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op_a     <= w_op_a_next;
      r_op_d     <= w_op_d_next;
      r_op_erase <= w_op_erase_next;
      r_op_host  <= w_op_host_next;
      r_cnt      <= w_cnt_next;
      r_ram_a    <= w_ram_a_next;
      r_ram_din  <= w_ram_din_next;
      r_ram_c1   <= w_ram_c1_next;
      r_ram_c2   <= w_ram_c2_next;
      r_ram_cs1  <= w_ram_cs1_next;
      r_ram_rclk <= w_ram_rclk_next;
      r_cpu_rd   <= w_cpu_rd_next;
      r_host_q   <= w_host_q_next;
      r_host_ack <= w_host_ack_next;
      if (cpu_addr_wr) begin
        r_lat_a <= cpu_a;
        r_lat_d <= cpu_d;
      end
      if (cpu_ctrl_wr) begin
        r_eclk_prev <= cpu_ctrl[0];
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign cpu_rd_data   = r_cpu_rd;
  assign host.host_q   = r_host_q;
  assign host.host_ack = r_host_ack;
  assign ram_a         = r_ram_a;
  assign ram_din       = r_ram_din;
  assign ram_c1        = r_ram_c1;
  assign ram_c2        = r_ram_c2;
  assign ram_cs1       = r_ram_cs1;
  assign ram_rclk      = r_ram_rclk;

endmodule

// File: tb/tb_earom_ctrl.sv
// Bench for earom_ctrl: array model plus a command/host-reply scoreboard and
// directed CPU, host, arbitration and reset scenarios.
module tb_earom_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_addr_wr;
  logic [5:0] cpu_a;
  logic [7:0] cpu_d;
  logic       cpu_ctrl_wr;
  logic [3:0] cpu_ctrl;
  logic [7:0] cpu_rd_data;
  logic       busy;
  logic [5:0] ram_a;
  logic [7:0] ram_din;
  logic       ram_c1, ram_c2, ram_cs1, ram_rclk;
  logic [7:0] ram_dout;

  earom_ctrl_if #(.ADDR_W(6)) hif ();

  earom_ctrl #(.ADDR_W(6), .BUSY_CYCLES(16), .BUSY_W(5)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr_wr(cpu_addr_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_ctrl_wr(cpu_ctrl_wr), .cpu_ctrl(cpu_ctrl),
    .cpu_rd_data(cpu_rd_data), .busy(busy),
    .host(hif.slave),
    .ram_a(ram_a), .ram_din(ram_din), .ram_c1(ram_c1), .ram_c2(ram_c2),
    .ram_cs1(ram_cs1), .ram_rclk(ram_rclk), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // EAROM array model: writes/erases while selected, registered read on rclk.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_cs1 && !ram_c1 && !ram_c2) mem[ram_a] <= ram_din;
    else if (ram_cs1 && !ram_c1 && ram_c2) mem[ram_a] <= 8'h00;
    if (ram_cs1 && ram_rclk) ram_dout <= mem[ram_a];
  end

  typedef struct {
    logic       c1;
    logic       c2;
    logic       rclk;
    logic [5:0] a;
    logic [7:0] din;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] hq_q[$];
  logic [7:0] exp_mem [64];
  logic       cs1_prev = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cmd_t e;
    if (ram_cs1) begin
      check_val("cs1_one_cycle", cs1_prev, 0);
      if (cmd_q.size() == 0) begin
        check_val("unexpected_cmd_a", ram_a, 32'hFFFF);
      end else begin
        e = cmd_q.pop_front();
        check_val("cmd_c1", ram_c1, e.c1);
        check_val("cmd_c2", ram_c2, e.c2);
        check_val("cmd_rclk", ram_rclk, e.rclk);
        check_val("cmd_a", ram_a, e.a);
        if (!e.rclk) check_val("cmd_din", ram_din, e.din);
        $display("cmd a=%0h din=%0h c1=%0b c2=%0b rclk=%0b", ram_a, ram_din, ram_c1, ram_c2, ram_rclk);
      end
    end
    if (hif.host_ack) begin
      if (hq_q.size() == 0) begin
        check_val("unexpected_ack_q", hif.host_q, 32'hFFFF);
      end else begin
        check_val("host_q", hif.host_q, hq_q.pop_front());
        $display("host_ack q=%0h", hif.host_q);
      end
    end
    cs1_prev <= ram_cs1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic addr_wr(input logic [5:0] a, input logic [7:0] d);
    cpu_addr_wr = 1'b1; cpu_a = a; cpu_d = d;
    tick();
    cpu_addr_wr = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [3:0] v);
    cpu_ctrl_wr = 1'b1; cpu_ctrl = v;
    tick();
    cpu_ctrl_wr = 1'b0;
  endtask

  task automatic push_cmd(input logic c1, input logic c2, input logic rclk,
                          input logic [5:0] a, input logic [7:0] din);
    cmd_t e;
    e.c1 = c1; e.c2 = c2; e.rclk = rclk; e.a = a; e.din = din;
    cmd_q.push_back(e);
    if (!c1) exp_mem[a] = c2 ? 8'h00 : din;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    if (busy) check_val("idle_timeout", busy, 0);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!hif.host_ack && n < 100);
    check_val("ack_seen", hif.host_ack, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_cs1"}, ram_cs1, 0);
    check_val({tag, "_c1"}, ram_c1, 1);
    check_val({tag, "_c2"}, ram_c2, 1);
    check_val({tag, "_rclk"}, ram_rclk, 0);
    check_val({tag, "_a"}, ram_a, 0);
    check_val({tag, "_din"}, ram_din, 0);
    check_val({tag, "_rd"}, cpu_rd_data, 0);
    check_val({tag, "_hq"}, hif.host_q, 0);
    check_val({tag, "_ack"}, hif.host_ack, 0);
    check_val({tag, "_busy"}, busy, 0);
    $display("reset check %s", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] seq [6];
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    ram_dout = 8'h00;
    reset = 1'b1; cpu_addr_wr = 1'b0; cpu_a = '0; cpu_d = '0;
    cpu_ctrl_wr = 1'b0; cpu_ctrl = '0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_a = '0; hif.host_d = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_state("init");

    // CPU write 0xA7 to address 5.
    addr_wr(6'h05, 8'hA7);
    ctrl_wr(4'h8);
    push_cmd(1'b0, 1'b0, 1'b0, 6'h05, 8'hA7);
    ctrl_wr(4'h9);
    wait_idle(n);
    check_val("write_busy_cycles", n, 17);
    $display("cpu write a=05 busy=%0d", n);

    // CPU read back with exact latency.
    ctrl_wr(4'hC);
    push_cmd(1'b1, 1'b0, 1'b1, 6'h05, 8'h00);
    ctrl_wr(4'hD);
    check_val("rd_rclk_hi", ram_rclk, 1);
    tick();
    check_val("rd_rclk_lo", ram_rclk, 0);
    tick();
    check_val("cpu_rd_a7", cpu_rd_data, 8'hA7);
    check_val("rd_done_busy", busy, 0);
    $display("cpu read a=05 data=%0h", cpu_rd_data);

    // Erase then read again.
    ctrl_wr(4'hA);
    push_cmd(1'b0, 1'b1, 1'b0, 6'h05, 8'hA7);
    ctrl_wr(4'hB);
    wait_idle(n);
    check_val("erase_busy_cycles", n, 17);
    ctrl_wr(4'hC);
    push_cmd(1'b1, 1'b0, 1'b1, 6'h05, 8'h00);
    ctrl_wr(4'hD);
    tick(); tick();
    check_val("cpu_rd_erased", cpu_rd_data, 8'h00);
    $display("cpu read after erase data=%0h", cpu_rd_data);

    // Write again, then a dropped trigger while busy.
    ctrl_wr(4'h8);
    push_cmd(1'b0, 1'b0, 1'b0, 6'h05, 8'hA7);
    ctrl_wr(4'h9);
    tick(); tick();
    addr_wr(6'h10, 8'h55);
    ctrl_wr(4'h8);
    ctrl_wr(4'h9);
    check_val("busy_hold_a", ram_a, 6'h05);
    check_val("busy_hold_busy", busy, 1);
    wait_idle(n);
    $display("dropped trigger during busy");

    // Same-cycle CPU read and host write: CPU wins.
    addr_wr(6'h05, 8'h00);
    ctrl_wr(4'hC);
    push_cmd(1'b1, 1'b0, 1'b1, 6'h05, 8'h00);
    push_cmd(1'b0, 1'b0, 1'b0, 6'h3F, 8'h99);
    hq_q.push_back(8'h00);
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_a = 6'h3F; hif.host_d = 8'h99;
    ctrl_wr(4'hD);
    tick(); tick();
    check_val("arb_cpu_rd", cpu_rd_data, 8'hA7);
    wait_ack(n);
    hif.host_req = 1'b0;
    wait_idle(n);
    $display("host write a=3f done");

    // Host read back.
    hq_q.push_back(8'h99);
    push_cmd(1'b1, 1'b0, 1'b1, 6'h3F, 8'h00);
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_a = 6'h3F;
    wait_ack(n);
    hif.host_req = 1'b0;
    check_val("host_rd_latency", n, 3);
    tick();
    check_val("host_ack_pulse", hif.host_ack, 0);
    $display("host read a=3f latency=%0d", n);

    // Reset during CMD.
    addr_wr(6'h20, 8'h11);
    ctrl_wr(4'h8);
    push_cmd(1'b0, 1'b0, 1'b0, 6'h20, 8'h11);
    ctrl_wr(4'h9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_cmd");
    repeat (20) tick();

    // Reset during BUSYW.
    addr_wr(6'h21, 8'h22);
    ctrl_wr(4'h8);
    push_cmd(1'b0, 1'b0, 1'b0, 6'h21, 8'h22);
    ctrl_wr(4'h9);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_busyw");
    repeat (20) tick();
    check_val("rst_busyw_idle", busy, 0);

    // No trigger: eclk held high or cs1 low.
    seq = '{4'h1, 4'h9, 4'h9, 4'hD, 4'h0, 4'h1};
    for (int i = 0; i < 6; i++) begin
      ctrl_wr(seq[i]);
      check_val("no_trig_busy", busy, 0);
      check_val("no_trig_cs1", ram_cs1, 0);
      $display("ctrl %0h no trigger", seq[i]);
    end
    repeat (5) tick();

    check_val("cmd_q_empty", cmd_q.size(), 0);
    check_val("hq_q_empty", hq_q.size(), 0);
    check_val("mem_05", mem[6'h05], exp_mem[6'h05]);
    check_val("mem_10", mem[6'h10], 8'h00);
    check_val("mem_3f", mem[6'h3F], 8'h99);
    check_val("mem_20", mem[6'h20], exp_mem[6'h20]);
    check_val("mem_21", mem[6'h21], exp_mem[6'h21]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
